// File: rtl/vend_seq_ctrl.sv
// Drink vending sequencer: coin credit, four-product selection, dispenser handshake and change payout.
// Optional build macro VEND_TIMEOUT_EN adds a vend_ack watchdog that refunds on expiry and pulses err.
module vend_seq_ctrl #(
  parameter int PRICE0 = 5,
  parameter int PRICE1 = 4,
  parameter int PRICE2 = 6,
  parameter int PRICE3 = 3
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       half,
  input  logic       one,
  input  logic [3:0] sel,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       hopper_rdy,
  output logic       vend_req,
  output logic [1:0] vend_id,
  output logic       coin_out,
  output logic       coin_rej,
  output logic       sel_nak,
  output logic [3:0] credit,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEND = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       vend_req_nxt;
  logic [1:0] vend_id_nxt;
  logic       coin_out_nxt;
  logic       coin_rej_nxt;
  logic       sel_nak_nxt;
  logic [3:0] credit_nxt;
  logic       busy_nxt;
  logic       err_nxt;

  logic       coin_in;
  logic       sel_hit;
  logic [1:0] sel_idx;
  logic [3:0] sel_price;
  logic [3:0] vend_rem;

  function automatic logic [3:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    return 4'(PRICE0);
      2'd1:    return 4'(PRICE1);
      2'd2:    return 4'(PRICE2);
      default: return 4'(PRICE3);
    endcase
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Credit never wraps: a coin that would push past 15 is refused outright.
  function automatic logic coin_fits(input logic [3:0] cr, input logic h, input logic o);
    logic [4:0] sum;
    sum = {1'b0, cr} + {3'b000, o, h};
    return (sum <= 5'd15);
  endfunction

`ifdef VEND_TIMEOUT_EN
  logic [7:0] to_cnt, to_cnt_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    vend_req_nxt = vend_req;
    vend_id_nxt  = vend_id;
    credit_nxt   = credit;
    coin_out_nxt = 1'b0;
    coin_rej_nxt = 1'b0;
    sel_nak_nxt  = 1'b0;
    err_nxt      = 1'b0;
`ifdef VEND_TIMEOUT_EN
    to_cnt_nxt   = 8'd0;
`endif
    coin_in   = half | one;
    sel_hit   = |sel;
    sel_idx   = lowest_idx(sel);
    sel_price = price_of(sel_idx);
    vend_rem  = credit - price_of(vend_id);

    case (state)
      IDLE: begin
        if (cancel && (credit != 4'd0)) begin
          state_nxt    = PAY;
          coin_rej_nxt = coin_in;
        end else if (sel_hit && (credit >= sel_price)) begin
          state_nxt    = VEND;
          vend_req_nxt = 1'b1;
          vend_id_nxt  = sel_idx;
          coin_rej_nxt = coin_in;
        end else begin
          // A refused selection still lets a same-cycle coin through.
          sel_nak_nxt = sel_hit;
          if (coin_in) begin
            if (coin_fits(credit, half, one))
              credit_nxt = credit + {2'b00, one, half};
            else
              coin_rej_nxt = 1'b1;
          end
        end
      end

      VEND: begin
        coin_rej_nxt = coin_in;
        if (vend_ack) begin
          vend_req_nxt = 1'b0;
          credit_nxt   = vend_rem;
          state_nxt    = (vend_rem != 4'd0) ? PAY : IDLE;
        end
`ifdef VEND_TIMEOUT_EN
        else if (to_cnt == 8'(TIMEOUT - 1)) begin
          err_nxt      = 1'b1;
          vend_req_nxt = 1'b0;
          state_nxt    = PAY;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
`endif
      end

      PAY: begin
        coin_rej_nxt = coin_in;
        if (hopper_rdy && (credit != 4'd0)) begin
          coin_out_nxt = 1'b1;
          credit_nxt   = credit - 4'd1;
          if (credit == 4'd1)
            state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt    = IDLE;
        vend_req_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // Registered outputs: every response lands one edge after its inputs are sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vend_req <= 1'b0;
      vend_id  <= 2'd0;
      coin_out <= 1'b0;
      coin_rej <= 1'b0;
      sel_nak  <= 1'b0;
      credit   <= 4'd0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      vend_req <= vend_req_nxt;
      vend_id  <= vend_id_nxt;
      coin_out <= coin_out_nxt;
      coin_rej <= coin_rej_nxt;
      sel_nak  <= sel_nak_nxt;
      credit   <= credit_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      to_cnt <= 8'd0;
    else
      to_cnt <= to_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed bench for vend_seq_ctrl (default build): expected output vectors are queued as each
// stimulus cycle is driven and popped for comparison one edge later.
module tb_vend_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       half, one, cancel, vend_ack, hopper_rdy;
  logic [3:0] sel;
  logic       vend_req, coin_out, coin_rej, sel_nak, busy, err;
  logic [1:0] vend_id;
  logic [3:0] credit;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  vend_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .half(half), .one(one), .sel(sel), .cancel(cancel),
    .vend_ack(vend_ack), .hopper_rdy(hopper_rdy), .vend_req(vend_req), .vend_id(vend_id),
    .coin_out(coin_out), .coin_rej(coin_rej), .sel_nak(sel_nak), .credit(credit),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Vector layout: {vend_req, vend_id, coin_out, coin_rej, sel_nak, credit, busy, err}
  function automatic logic [11:0] ev(input logic req, input logic [1:0] id, input logic co,
                                     input logic rej, input logic nak, input logic [3:0] cr,
                                     input logic bsy);
    return {req, id, co, rej, nak, cr, bsy, 1'b0};
  endfunction

  task automatic step(input string tag, input logic h, input logic o, input logic [3:0] s,
                      input logic c, input logic ack, input logic rdy, input logic [11:0] e);
    logic [11:0] obs, exp_v;
    string t;
    half = h; one = o; sel = s; cancel = c; vend_ack = ack; hopper_rdy = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs   = {vend_req, vend_id, coin_out, coin_rej, sel_nak, credit, busy, err};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h (req,id,cout,rej,nak,credit,busy,err)",
             t, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset dominates even with coins present
    step("rst0", 1, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,0,0));
    step("rst1", 0, 0, 4'b0001, 1, 1, 1, ev(0,0,0,0,0,0,0));
    rst_n = 1'b1;

    // Exact-price vend of product 0
    step("t1_one_a", 0, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,2,0));
    step("t1_one_b", 0, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,4,0));
    step("t1_half",  1, 0, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,5,0));
    step("t1_sel0",  0, 0, 4'b0001, 0, 0, 1, ev(1,0,0,0,0,5,1));
    step("t1_wait",  0, 0, 4'b0000, 0, 0, 1, ev(1,0,0,0,0,5,1));
    step("t1_ack",   0, 0, 4'b0000, 0, 1, 1, ev(0,0,0,0,0,0,0));
    step("t1_idle",  0, 0, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,0,0));

    // Product 3 with change, hopper_rdy toggling; coin and sel in PAY are ignored/rejected
    step("t2_one_a", 0, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,2,0));
    step("t2_one_b", 0, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,4,0));
    step("t2_one_c", 0, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,6,0));
    step("t2_sel3",  0, 0, 4'b1000, 0, 0, 1, ev(1,3,0,0,0,6,1));
    step("t2_ack",   0, 0, 4'b0000, 0, 1, 1, ev(0,3,0,0,0,3,1));
    step("t2_pay1",  0, 0, 4'b0000, 0, 0, 1, ev(0,3,1,0,0,2,1));
    step("t2_hold1", 0, 1, 4'b0001, 0, 0, 0, ev(0,3,0,1,0,2,1));
    step("t2_pay2",  0, 0, 4'b0000, 0, 0, 1, ev(0,3,1,0,0,1,1));
    step("t2_hold2", 0, 0, 4'b0000, 1, 0, 0, ev(0,3,0,0,0,1,1));
    step("t2_pay3",  0, 0, 4'b0000, 0, 0, 1, ev(0,3,1,0,0,0,0));
    step("t2_idle",  0, 0, 4'b0000, 0, 0, 1, ev(0,3,0,0,0,0,0));

    // Insufficient credit then cancel refund
    step("t3_one_a", 0, 1, 4'b0000, 0, 0, 1, ev(0,3,0,0,0,2,0));
    step("t3_one_b", 0, 1, 4'b0000, 0, 0, 1, ev(0,3,0,0,0,4,0));
    step("t3_nak",   0, 0, 4'b0100, 0, 0, 1, ev(0,3,0,0,1,4,0));
    step("t3_cancel",0, 0, 4'b0000, 1, 0, 1, ev(0,3,0,0,0,4,1));
    for (int k = 3; k >= 0; k--)
      step("t3_pay", 0, 0, 4'b0000, 0, 0, 1, ev(0,3,1,0,0,4'(k),(k != 0)));
    step("t3_idle",  0, 0, 4'b0000, 0, 0, 1, ev(0,3,0,0,0,0,0));

    // Cancel at zero credit is ignored; coin with refused sel counts; lowest sel index wins
    step("t4_cancel0",  0, 1, 4'b0000, 1, 0, 1, ev(0,3,0,0,0,2,0));
    step("t4_nak_coin", 1, 0, 4'b0010, 0, 0, 1, ev(0,3,0,0,1,3,0));
    step("t4_one",      0, 1, 4'b0000, 0, 0, 1, ev(0,3,0,0,0,5,0));
    step("t4_multisel", 0, 0, 4'b1110, 0, 0, 1, ev(1,1,0,0,0,5,1));
    step("t4_vendcoin", 0, 1, 4'b0000, 0, 0, 1, ev(1,1,0,1,0,5,1));
    step("t4_ack",      0, 0, 4'b0000, 0, 1, 1, ev(0,1,0,0,0,1,1));
    step("t4_pay",      0, 0, 4'b0000, 0, 0, 1, ev(0,1,1,0,0,0,0));

    // Overflow boundary at 14/15
    for (int i = 1; i <= 7; i++)
      step("t5_fill", 0, 1, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,4'(2*i),0));
    step("t5_both_rej", 1, 1, 4'b0000, 0, 0, 1, ev(0,1,0,1,0,14,0));
    step("t5_half15",   1, 0, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,15,0));
    step("t5_half_rej", 1, 0, 4'b0000, 0, 0, 1, ev(0,1,0,1,0,15,0));
    step("t5_cancel",   0, 0, 4'b0000, 1, 0, 1, ev(0,1,0,0,0,15,1));
    for (int k = 14; k >= 0; k--)
      step("t5_pay", 0, 0, 4'b0000, 0, 0, 1, ev(0,1,1,0,0,4'(k),(k != 0)));

    // sel + cancel + coin together: cancel wins, coin rejected, no vend
    step("t6_one_a", 0, 1, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,2,0));
    step("t6_one_b", 0, 1, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,4,0));
    step("t6_half",  1, 0, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,5,0));
    step("t6_all",   0, 1, 4'b0001, 1, 0, 1, ev(0,1,0,1,0,5,1));
    for (int k = 4; k >= 0; k--)
      step("t6_pay", 0, 0, 4'b0000, 0, 0, 1, ev(0,1,1,0,0,4'(k),(k != 0)));

    // Reset in the middle of VEND drops everything at the next edge
    step("t7_one_a", 0, 1, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,2,0));
    step("t7_one_b", 0, 1, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,4,0));
    step("t7_half",  1, 0, 4'b0000, 0, 0, 1, ev(0,1,0,0,0,5,0));
    step("t7_sel0",  0, 0, 4'b0001, 0, 0, 1, ev(1,0,0,0,0,5,1));
    step("t7_wait",  0, 0, 4'b0000, 0, 0, 1, ev(1,0,0,0,0,5,1));
    rst_n = 1'b0;
    step("t7_rst",   0, 0, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,0,0));
    rst_n = 1'b1;
    step("t7_stray_ack", 0, 0, 4'b0000, 0, 1, 1, ev(0,0,0,0,0,0,0));
    step("t7_one",   0, 1, 4'b0000, 0, 0, 1, ev(0,0,0,0,0,2,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_seq_ctrl.md
# vend_seq_ctrl

Sequencing controller for the drink vending datapath. It accepts 0.5 and 1 coin pulses into a credit register, serves a selection among four products with individual prices, and drives the dispenser through a req/ack handshake. It then pays change to the coin hopper one 0.5 unit at a time. It sits between the coin/keypad front end and the dispenser/hopper actuators, replacing the fixed-price single-product flow.

## Interface
- PRICE0, default 5, price of product 0 in 0.5 units (5 = 2.5)
- PRICE1, default 4, price of product 1 in 0.5 units
- PRICE2, default 6, price of product 2 in 0.5 units
- PRICE3, default 3, price of product 3 in 0.5 units
- TIMEOUT, default 255, cycles to wait for vend_ack before refund (only with VEND_TIMEOUT_EN)
- All prices are 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- half  in  1  0.5 coin, one-cycle pulse
- one  in  1  1.0 coin, one-cycle pulse
- sel  in  4  product select, one-cycle pulse, bit i = product i
- cancel  in  1  refund request, one-cycle pulse
- vend_ack  in  1  dispenser has taken the request
- hopper_rdy  in  1  hopper can accept a payout pulse
- vend_req  out  1  dispense request
- vend_id  out  2  product index, valid while vend_req=1
- coin_out  out  1  pay out one 0.5 unit, one-cycle pulse
- coin_rej  out  1  the coin(s) just inserted are returned, one-cycle pulse
- sel_nak  out  1  selection refused for insufficient credit, one-cycle pulse
- credit  out  4  current credit in 0.5 units
- busy  out  1  high in any state except IDLE
- err  out  1  vend timeout, one-cycle pulse

## Operation
- States:
  - IDLE: accepts coins, sel and cancel.
  - VEND: vend_req high until vend_ack is sampled high.
  - PAY: pays out the remaining credit.
- IDLE coin handling:
  - Coin value = half + 2*one; half and one in the same cycle add 3.
  - If credit + value > 15, credit is unchanged and coin_rej pulses.
- IDLE selection:
  - When several sel bits are set, the lowest index wins.
  - If credit >= price: latch vend_id and go to VEND.
  - Otherwise pulse sel_nak and stay in IDLE.
  - sel is evaluated against the credit before this cycle's coin add.
- IDLE cancel: if credit > 0, go to PAY; if credit = 0, ignore.
- Priority in the same cycle: cancel > sel > coin.
  - A coin arriving in the same cycle as an accepted sel or cancel is rejected (coin_rej).
  - A coin arriving with a refused sel is counted.
- Coins arriving in VEND or PAY are rejected with coin_rej. sel and cancel are ignored in VEND and PAY.
- VEND, when vend_ack is sampled high:
  - credit -= price(vend_id).
  - Go to PAY if the remainder > 0, else go to IDLE.
- PAY:
  - Each cycle with hopper_rdy=1 and credit > 0: coin_out=1 and credit decrements by 1.
  - Go to IDLE when credit reaches 0.
- Credit arithmetic is 4-bit unsigned. It never wraps: overflow is rejected as above, and underflow cannot occur because price <= credit is checked on entry to VEND.

## Timing
- Reset values: vend_req=0, vend_id=0, coin_out=0, coin_rej=0, sel_nak=0, credit=0, busy=0, err=0; state IDLE.
- Reset asserted mid-operation: the next edge forces the reset values. Credit is lost, and vend_req drops at that edge.
- All outputs are registered. Every response appears one cycle after the input is sampled.
- Coin at edge N: credit is updated (or coin_rej pulses) after edge N.
- Accepted sel at edge N: vend_req=1 and busy=1 after edge N.
- vend_ack high at edge M: vend_req=0 and credit is reduced after edge M. The first possible coin_out is after edge M+1.
- coin_out may be high in consecutive cycles while hopper_rdy stays high.
- PAY to IDLE: busy drops in the same cycle credit reaches 0. A new coin or sel is accepted from the next edge.

## Configuration
- VEND_TIMEOUT_EN defined:
  - An 8-bit counter runs in VEND.
  - If vend_ack has not been seen after TIMEOUT cycles: err pulses, vend_req drops, credit is left intact, and the FSM goes to PAY (full refund).
  - vend_ack in the same cycle as expiry counts as acknowledged (no err).
- VEND_TIMEOUT_EN undefined: VEND waits indefinitely for vend_ack; err is tied to 0.

## Test plan
- Insert one, one, half (credit 5), then sel=4'b0001 -> vend_req=1, vend_id=0. On vend_ack: credit=0, no coin_out, busy=0.
- Insert one x3 (credit 6), then sel=4'b1000 (price 3) -> after ack, exactly 3 coin_out pulses; with hopper_rdy toggling 1,0,1,0,1, pulses land only in hopper_rdy=1 cycles.
- Credit 4, sel=4'b0100 (price 6) -> sel_nak pulse, credit stays 4; then cancel -> 4 coin_out pulses, credit 0.
- Credit 14, half+one in the same cycle -> coin_rej=1, credit stays 14; then half -> credit 15; then half -> coin_rej.
- sel + cancel + one in the same cycle with credit 5 -> refund 5 units, coin_rej=1, no vend_req.
- VEND_TIMEOUT_EN with TIMEOUT=10, credit 5, sel=4'b0001, no ack -> err pulse after 10 cycles in VEND, vend_req=0, 5 coin_out pulses. Repeat with rst_n=0 mid-VEND -> all outputs 0 at the next edge.
